pwm_deadtime_gen: RTL and testbench
===================================

PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 Parameter DEADTIME, default 12'd30, dead-time length in clk cycles (1 us at 30 MHz).
REQ-002 Parameter DUTY_MAX, default 12'd4090, upper clamp for the latched duty.
REQ-003 clk  input  1  system clock (30 MHz); the only clock; all logic SHALL be rising-edge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ctrl_data  input  12  commanded duty from the current-loop controller.
REQ-006 torque_flag  input  1  controller-running flag; 1 enables switching.
REQ-007 BrakeMode  input  2  00 qudong, 01 fanjie, 10 nenghao, 11 anquan.
REQ-008 over_in  input  1  nenghao overflow indication (ModeNH_Over_Flag).
REQ-009 Clr_flag  input  1  fault clear request, level.
REQ-010 pwm_h  output  1  high-side gate drive, registered.
REQ-011 pwm_l  output  1  low-side gate drive, registered.
REQ-012 period_start  output  1  one-cycle pulse when cnt==0 in ST_RUN.
REQ-013 fault  output  1  sticky fault, registered.
REQ-014 duty_act  output  12  duty currently applied (shadow register).

Function
REQ-015 Free-running 12-bit cnt SHALL count 0..4095 and wrap to 0; period = 4096 clk.
REQ-016 At cnt==4095, duty_act SHALL load min(ctrl_data, DUTY_MAX); at all other cnt values duty_act SHALL hold, so mid-period ctrl_data changes take effect only at the next period.
REQ-017 raw_r SHALL register (cnt < duty_act) each cycle.
REQ-018 dt_cnt SHALL clear to 0 on any cycle where raw_r changes value, else increment, saturating at DEADTIME.
REQ-019 States: ST_OFF, ST_ARM, ST_RUN, ST_FAULT; encoding 2 bits.
REQ-020 en = torque_flag && (BrakeMode != 2'b11) && !fault.
REQ-021 ST_OFF -> ST_ARM when en; ST_ARM -> ST_RUN on the cycle cnt==4095; ST_ARM or ST_RUN -> ST_OFF the cycle en falls.
REQ-022 over_in==1 in any state SHALL set fault and enter ST_FAULT; over_in has priority over all other transitions.
REQ-023 ST_FAULT -> ST_OFF only when Clr_flag==1 and over_in==0; fault clears on that same edge.
REQ-024 In ST_RUN: pwm_h <= raw_r && (dt_cnt==DEADTIME); pwm_l <= !raw_r && (dt_cnt==DEADTIME).
REQ-025 Outside ST_RUN pwm_h and pwm_l SHALL be 0 on the next edge (one-cycle shutdown latency).
REQ-026 pwm_h and pwm_l SHALL never be 1 in the same cycle.
REQ-027 Per steady period: pwm_h high max(0, duty_act-DEADTIME) cycles, pwm_l high max(0, 4096-duty_act-DEADTIME) cycles.
REQ-028 duty_act==0: pwm_h never asserts; raw_r constant so pwm_l stays 1 across the wrap.
REQ-029 duty_act <= DEADTIME: pwm_h SHALL stay 0; pwm_l still drops for the gap.

Reset
REQ-030 On rst: cnt=0, state ST_OFF, duty_act=0, raw_r=0, dt_cnt=0, pwm_h=0, pwm_l=0, period_start=0, fault=0.
REQ-031 rst mid-period SHALL drop both gates on the next edge and restart cnt at 0.

Verification
REQ-032 ctrl_data=1000, torque_flag=1, BrakeMode=00 -> after arm, each period pwm_h=1 for 970 cycles, pwm_l=1 for 3066, 30-cycle both-low gaps at both edges.
REQ-033 ctrl_data=4095 -> duty_act=4090; pwm_h=1 for 4060 cycles, pwm_l never 1.
REQ-034 ctrl_data 1000->2000 at cnt=500 -> current period keeps 1000, next period pwm_h=1970 cycles.
REQ-035 BrakeMode->11 at cnt=200 in ST_RUN -> pwm_h=pwm_l=0 next edge; return to 00 -> re-arm, switching resumes at next cnt==0.
REQ-036 over_in pulse 1 cycle -> fault=1, gates 0, stays until Clr_flag=1; then ST_OFF, re-arm with torque_flag=1.
REQ-037 Random ctrl_data/BrakeMode/rst stimulus 1e6 cycles -> assertion pwm_h&&pwm_l never true.

Source files
------------

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen
//   Complementary PWM pair with dead-time insertion and a sticky overflow fault.
//   A free-running 12-bit counter sets a 4096-clk period. The duty is latched
//   once per period into a shadow register, so the edges inside a period are
//   always built from one duty value. A settling counter (dt_cnt) holds both
//   gates low for DEADTIME cycles after every raw PWM transition.
//
// Ports
//   clk          system clock, rising edge only
//   rst          synchronous active-high reset
//   ctrl_data    commanded duty (0..4095, clamped to DUTY_MAX when latched)
//   torque_flag  controller running; 1 enables switching
//   BrakeMode    00 qudong, 01 fanjie, 10 nenghao, 11 anquan (11 = gates off)
//   over_in      nenghao overflow; forces the fault state
//   Clr_flag     fault clear request (level)
//   pwm_h/pwm_l  registered high/low side gate drives
//   period_start one-cycle pulse in the cycle cnt==0 while running
//   fault        sticky fault flag
//   duty_act     duty applied in the current period
module pwm_deadtime_gen #(
    parameter logic [11:0] DEADTIME = 12'd30,
    parameter logic [11:0] DUTY_MAX = 12'd4090
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ctrl_data,
    input  logic        torque_flag,
    input  logic [1:0]  BrakeMode,
    input  logic        over_in,
    input  logic        Clr_flag,
    output logic        pwm_h,
    output logic        pwm_l,
    output logic        period_start,
    output logic        fault,
    output logic [11:0] duty_act
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        fault_nxt;
    logic [11:0] cnt;
    logic [11:0] dt_cnt;
    logic        raw_r;
    logic        raw_nxt;
    logic        cnt_last;
    logic        dt_done;
    logic        en;
    logic        run_nxt;

    assign cnt_last = (cnt == 12'hFFF);
    assign raw_nxt  = (cnt < duty_act);
    assign dt_done  = (dt_cnt == DEADTIME);
    assign en       = torque_flag && (BrakeMode != 2'b11) && !fault;
    // Gates follow the state being entered, so any exit from ST_RUN (enable
    // drop, fault, reset) clears them on the very next edge.
    assign run_nxt  = (state_nxt == ST_RUN);

    always_comb begin
        state_nxt = state;
        fault_nxt = fault;
        if (over_in) begin
            // overflow overrides every other transition, including clear
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
        end else begin
            case (state)
                ST_OFF:   if (en) state_nxt = ST_ARM;
                ST_ARM: begin
                    if (!en)           state_nxt = ST_OFF;
                    else if (cnt_last) state_nxt = ST_RUN;
                end
                ST_RUN:   if (!en) state_nxt = ST_OFF;
                ST_FAULT: begin
                    if (Clr_flag) begin
                        state_nxt = ST_OFF;
                        fault_nxt = 1'b0;
                    end
                end
                default:  state_nxt = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 12'd0;
            state        <= ST_OFF;
            duty_act     <= 12'd0;
            raw_r        <= 1'b0;
            dt_cnt       <= 12'd0;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            period_start <= 1'b0;
            fault        <= 1'b0;
        end else begin
            cnt   <= cnt + 12'd1;
            state <= state_nxt;
            fault <= fault_nxt;
            // shadow load on the last count: the new duty governs the whole
            // next period starting at cnt==0
            if (cnt_last)
                duty_act <= (ctrl_data > DUTY_MAX) ? DUTY_MAX : ctrl_data;
            raw_r <= raw_nxt;
            // restart the settling window on every raw edge, else saturate
            if (raw_nxt != raw_r)
                dt_cnt <= 12'd0;
            else if (!dt_done)
                dt_cnt <= dt_cnt + 12'd1;
            // raw_r and !raw_r are exclusive, so the pair can never overlap
            pwm_h        <= run_nxt &&  raw_r && dt_done;
            pwm_l        <= run_nxt && !raw_r && dt_done;
            period_start <= run_nxt && cnt_last;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: a duty table measured over full
// periods, plus sequences for shadow loading, brake-off, fault and reset.
module tb_pwm_deadtime_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ctrl_data;
    logic        torque_flag;
    logic [1:0]  BrakeMode;
    logic        over_in;
    logic        Clr_flag;
    logic        pwm_h, pwm_l, period_start, fault;
    logic [11:0] duty_act;

    int checks = 0;
    int errors = 0;

    // reference period counter: restarts with rst, wraps every 4096 clk
    logic [11:0] tb_cnt;

    typedef struct {
        logic [11:0] ctrl;
        int          duty;
        int          h_cyc;
        int          l_cyc;
    } vec_t;

    vec_t tab [9];

    pwm_deadtime_gen dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_data    (ctrl_data),
        .torque_flag  (torque_flag),
        .BrakeMode    (BrakeMode),
        .over_in      (over_in),
        .Clr_flag     (Clr_flag),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start),
        .fault        (fault),
        .duty_act     (duty_act)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cnt <= rst ? 12'd0 : tb_cnt + 12'd1;

    // gates must never overlap, checked every cycle
    always @(negedge clk) begin
        checks++;
        if (pwm_h === 1'b1 && pwm_l === 1'b1) begin
            errors++;
            $display("FAIL overlap: pwm_h=1 pwm_l=1 at t=%0t, required not both 1", $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance until tb_cnt==v, counting cycles where either gate was high
    task automatic run_to(input int v, output int hi);
        int guard;
        hi = 0;
        guard = 0;
        while (tb_cnt != v[11:0] && guard < 5000) begin
            if (pwm_h || pwm_l) hi++;
            tick();
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL run_to timeout: got no cnt==%0d, required within 5000 cycles", v);
        end
    endtask

    // 4096 samples starting now; with a start at cnt 2 the window covers
    // one full period of the present duty independent of the previous one
    task automatic measure(output int h, output int l, output int ps, output int ps_at);
        h = 0; l = 0; ps = 0; ps_at = -1;
        for (int k = 0; k < 4096; k++) begin
            if (pwm_h) h++;
            if (pwm_l) l++;
            if (period_start) begin
                ps++;
                ps_at = int'(tb_cnt);
            end
            tick();
        end
    endtask

    initial begin
        int hi, h, l, ps, ps_at;

        tab[0] = '{12'd1000, 1000,  970, 3066};
        tab[1] = '{12'd4095, 4090, 4060,    0};
        tab[2] = '{12'd30,     30,    0, 4036};
        tab[3] = '{12'd0,       0,    0, 4096};
        tab[4] = '{12'd31,     31,    1, 4035};
        tab[5] = '{12'd10,     10,    0, 4056};
        tab[6] = '{12'd4091, 4090, 4060,    0};
        tab[7] = '{12'd2048, 2048, 2018, 2018};
        tab[8] = '{12'd1000, 1000,  970, 3066};

        rst = 1'b1; ctrl_data = tab[0].ctrl; torque_flag = 1'b1;
        BrakeMode = 2'b00; over_in = 1'b0; Clr_flag = 1'b0;
        repeat (3) tick();
        chk("reset pwm_h", pwm_h, 0);
        chk("reset pwm_l", pwm_l, 0);
        chk("reset fault", fault, 0);
        chk("reset period_start", period_start, 0);
        chk("reset duty_act", duty_act, 0);
        rst = 1'b0;

        // arming period: no switching until the first wrap
        run_to(4095, hi);
        chk("arm gates quiet", hi, 0);

        for (int i = 0; i < 9; i++) begin
            run_to(2, hi);
            chk($sformatf("tab%0d duty_act", i), duty_act, tab[i].duty);
            if (i < 8) ctrl_data = tab[i+1].ctrl;
            measure(h, l, ps, ps_at);
            chk($sformatf("tab%0d pwm_h cycles", i), h, tab[i].h_cyc);
            chk($sformatf("tab%0d pwm_l cycles", i), l, tab[i].l_cyc);
            chk($sformatf("tab%0d period_start count", i), ps, 1);
            chk($sformatf("tab%0d period_start cnt", i), ps_at, 0);
        end

        // mid-period duty change waits for the next period
        run_to(500, hi);
        ctrl_data = 12'd2000;
        run_to(600, hi);
        chk("shadow hold duty_act", duty_act, 1000);
        run_to(1001, hi);
        chk("old duty pwm_h@1001", pwm_h, 1);
        tick();
        chk("old duty pwm_h@1002", pwm_h, 0);
        run_to(2, hi);
        chk("new duty_act", duty_act, 2000);
        measure(h, l, ps, ps_at);
        chk("duty2000 pwm_h cycles", h, 1970);
        chk("duty2000 pwm_l cycles", l, 2066);

        // brake to anquan stops gates next edge, re-arms on return
        run_to(200, hi);
        chk("pre-brake pwm_h", pwm_h, 1);
        BrakeMode = 2'b11;
        tick();
        chk("brake pwm_h", pwm_h, 0);
        chk("brake pwm_l", pwm_l, 0);
        run_to(300, hi);
        BrakeMode = 2'b00;
        run_to(4095, h);
        chk("brake gates quiet", hi + h, 0);
        tick();
        chk("rearm period_start", period_start, 1);
        run_to(40, hi);
        chk("rearm pwm_h@40", pwm_h, 1);

        // one-cycle overflow: sticky fault, clear blocked while over_in high
        run_to(500, hi);
        over_in = 1'b1;
        tick();
        over_in = 1'b0;
        chk("fault set", fault, 1);
        chk("fault pwm_h", pwm_h, 0);
        chk("fault pwm_l", pwm_l, 0);
        repeat (10) tick();
        chk("fault sticky", fault, 1);
        Clr_flag = 1'b1; over_in = 1'b1;
        tick();
        chk("clear blocked by over_in", fault, 1);
        over_in = 1'b0;
        tick();
        Clr_flag = 1'b0;
        chk("fault cleared", fault, 0);
        run_to(4095, hi);
        chk("post-fault gates quiet", hi, 0);
        tick();
        chk("post-fault period_start", period_start, 1);
        run_to(40, hi);
        chk("post-fault pwm_h@40", pwm_h, 1);

        // reset mid-period drops gates and restarts the counter
        run_to(1500, hi);
        chk("pre-rst pwm_h", pwm_h, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst pwm_h", pwm_h, 0);
        chk("mid rst pwm_l", pwm_l, 0);
        chk("mid rst duty_act", duty_act, 0);
        run_to(4095, hi);
        chk("post-rst gates quiet", hi, 0);
        chk("post-rst no early start", period_start, 0);
        tick();
        chk("post-rst period_start at cnt0", period_start, 1);
        chk("post-rst duty_act", duty_act, 2000);

        // random soak; the overlap monitor is the check here
        for (int k = 0; k < 9000; k++) begin
            ctrl_data   = 12'($urandom);
            if ($urandom_range(0, 199) == 0) BrakeMode = 2'($urandom);
            torque_flag = ($urandom_range(0, 999) != 0);
            over_in     = ($urandom_range(0, 2999) == 0);
            Clr_flag    = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 4999) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
